// File: rtl/btree_find_walker.sv
// Root-to-leaf search initiator for the B-tree node bank: presents one node per
// ISSUE cycle, registers the bank response, and decides the next hop in EVAL.
module btree_find_walker #(
  parameter logic [7:0]  ROOT      = 8'd1,
  parameter int unsigned MAX_STEPS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [3:0] i_key,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_found,
  output logic [3:0] o_data,
  output logic [7:0] o_steps,
  output logic       o_overrun,
  output logic [7:0] o_node_address,
  output logic [3:0] o_node_key,
  input  logic       i_node_found,
  input  logic [3:0] i_node_data,
  input  logic [7:0] i_node_next
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_EVAL,
    S_DONE
  } state_t;

  localparam logic [7:0] LP_MAX = 8'(MAX_STEPS);

  state_t     r_state;
  state_t     w_next_state;

  // r_addr doubles as the current-node pointer and the registered bus address
  logic [7:0] r_addr;
  logic [3:0] r_key;
  logic       r_rsp_found;
  logic [3:0] r_rsp_data;
  logic [7:0] r_rsp_next;
  logic       r_found;
  logic [3:0] r_data;
  logic [7:0] r_steps;
  logic       r_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = S_EVAL;
      S_EVAL: begin
        if (r_rsp_found || (r_rsp_next == '0) || (r_steps == LP_MAX)) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_ISSUE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state != S_IDLE);
    o_done = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_key       <= '0;
      r_rsp_found <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_next  <= '0;
      r_found     <= 1'b0;
      r_data      <= '0;
      r_steps     <= '0;
      r_overrun   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_key     <= i_key;
            r_addr    <= ROOT;
            r_steps   <= '0;
            r_found   <= 1'b0;
            r_data    <= '0;
            r_overrun <= 1'b0;
          end
        end
        S_ISSUE: begin
          r_rsp_found <= i_node_found;
          r_rsp_data  <= i_node_data;
          r_rsp_next  <= i_node_next;
          if (r_steps != LP_MAX) r_steps <= r_steps + 8'd1;
        end
        S_EVAL: begin
          // a hit wins even when the node also reports a nonzero child
          if (r_rsp_found) begin
            r_found <= 1'b1;
            r_data  <= r_rsp_data;
          end else if (r_rsp_next == '0) begin
            r_found <= 1'b0;
            r_data  <= '0;
          end else if (r_steps == LP_MAX) begin
            r_overrun <= 1'b1;
          end else begin
            r_addr <= r_rsp_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_found        = r_found;
  assign o_data         = r_data;
  assign o_steps        = r_steps;
  assign o_overrun      = r_overrun;
  assign o_node_address = r_addr;
  assign o_node_key     = r_key;

endmodule

// File: tb/tb_btree_find_walker.sv
// Bench for btree_find_walker: table-driven vectors on a fixed tree, hand-written
// corner sequences, and random trees checked against a tree-walk model.
module tb_btree_find_walker;

  localparam int unsigned TB_MAX  = 3;
  localparam logic [7:0]  TB_ROOT = 8'd1;

  logic       clk;
  logic       rst_n;
  logic       i_start;
  logic [3:0] i_key;
  logic       o_busy;
  logic       o_done;
  logic       o_found;
  logic [3:0] o_data;
  logic [7:0] o_steps;
  logic       o_overrun;
  logic [7:0] o_node_address;
  logic [3:0] o_node_key;
  logic       i_node_found;
  logic [3:0] i_node_data;
  logic [7:0] i_node_next;

  int checks = 0;
  int errors = 0;

  btree_find_walker #(
    .ROOT      (TB_ROOT),
    .MAX_STEPS (TB_MAX)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (i_start),
    .i_key          (i_key),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_found        (o_found),
    .o_data         (o_data),
    .o_steps        (o_steps),
    .o_overrun      (o_overrun),
    .o_node_address (o_node_address),
    .o_node_key     (o_node_key),
    .i_node_found   (i_node_found),
    .i_node_data    (i_node_data),
    .i_node_next    (i_node_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Node bank: per node, per key lookup tables; addresses >= 16 are empty nodes.
  logic       bank_found [16][16];
  logic [3:0] bank_data  [16][16];
  logic [7:0] bank_next  [16][16];

  // Bank answers half a cycle after the address moves, well before the sampling edge.
  always @(negedge clk) begin
    if (o_node_address < 8'd16) begin
      i_node_found <= bank_found[o_node_address[3:0]][o_node_key];
      i_node_data  <= bank_data[o_node_address[3:0]][o_node_key];
      i_node_next  <= bank_next[o_node_address[3:0]][o_node_key];
    end else begin
      i_node_found <= 1'b0;
      i_node_data  <= '0;
      i_node_next  <= '0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_bank();
    for (int n = 0; n < 16; n++) begin
      for (int k = 0; k < 16; k++) begin
        bank_found[n][k] = 1'b0;
        bank_data[n][k]  = '0;
        bank_next[n][k]  = '0;
      end
    end
  endtask

  // Root keys {2,5,8}->{3,6,9}; keys below 2 go to node 2, 2..7 to node 3, above to node 5.
  // Node 3 holds {6,7,0}->{1,2,0} and has no children.
  task automatic load_fixed_tree();
    clear_bank();
    for (int k = 0; k < 16; k++) begin
      bank_next[1][k] = (k < 2) ? 8'd2 : (k < 8) ? 8'd3 : 8'd5;
    end
    bank_found[1][2] = 1'b1; bank_data[1][2] = 4'd3;
    bank_found[1][5] = 1'b1; bank_data[1][5] = 4'd6;
    bank_found[1][8] = 1'b1; bank_data[1][8] = 4'd9;
    bank_found[3][6] = 1'b1; bank_data[3][6] = 4'd1;
    bank_found[3][7] = 1'b1; bank_data[3][7] = 4'd2;
    bank_found[3][0] = 1'b1; bank_data[3][0] = 4'd0;
  endtask

  task automatic load_loop_tree();
    clear_bank();
    for (int k = 0; k < 16; k++) bank_next[1][k] = 8'd1;
  endtask

  task automatic load_random_tree();
    clear_bank();
    for (int n = 1; n < 16; n++) begin
      for (int k = 0; k < 16; k++) begin
        bank_found[n][k] = ($urandom_range(0, 4) == 0);
        bank_data[n][k]  = 4'($urandom_range(0, 15));
        bank_next[n][k]  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 15));
      end
    end
  endtask

  // Reference: walk the bank tables from the root, one visit at a time.
  function automatic void walk(input logic [3:0] k, output logic f, output logic [3:0] d,
                               output int s, output logic o);
    logic [7:0] cur;
    logic [7:0] nxt;
    cur = TB_ROOT;
    f = 1'b0; d = '0; s = 0; o = 1'b0;
    for (int v = 1; v <= int'(TB_MAX); v++) begin
      s = v;
      if (bank_found[cur[3:0]][k]) begin
        f = 1'b1;
        d = bank_data[cur[3:0]][k];
        return;
      end
      nxt = bank_next[cur[3:0]][k];
      if (nxt == 8'd0) return;
      if (v == int'(TB_MAX)) begin
        o = 1'b1;
        return;
      end
      cur = nxt;
    end
  endfunction

  // Starts a search at the next falling edge; returns cycles from the start cycle to done.
  task automatic search(input logic [3:0] k, input logic glitch, input logic [3:0] gkey,
                        output int cyc);
    @(negedge clk);
    chk("idle_before_start", {o_busy, o_done}, 0);
    i_start = 1'b1;
    i_key   = k;
    cyc     = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("issue_addr", o_node_address, TB_ROOT);
        chk("issue_key", o_node_key, k);
        chk("busy_after_start", o_busy, 1);
        i_start = glitch;
        i_key   = gkey;
      end else begin
        i_start = 1'b0;
      end
      if (o_done) break;
    end
    i_start = 1'b0;
    if (!o_done) chk("done_timeout", 0, 1);
  endtask

  task automatic check_result(input string tag, input logic f, input logic [3:0] d,
                              input int s, input logic o, input int cyc_got);
    chk({tag, "_found"}, o_found, f);
    chk({tag, "_data"}, o_data, d);
    chk({tag, "_steps"}, o_steps, s);
    chk({tag, "_overrun"}, o_overrun, o);
    chk({tag, "_latency"}, cyc_got, 2 * s + 1);
  endtask

  typedef struct {
    logic [3:0] key;
    logic       ef;
    logic [3:0] ed;
    int         es;
    logic       eo;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int         cyc;
    logic       mf;
    logic [3:0] md;
    int         ms;
    logic       mo;
    logic [3:0] rk;
    bit         saw_done;

    vecs[0] = '{key: 4'd5, ef: 1'b1, ed: 4'd6, es: 1, eo: 1'b0};
    vecs[1] = '{key: 4'd7, ef: 1'b1, ed: 4'd2, es: 2, eo: 1'b0};
    vecs[2] = '{key: 4'd6, ef: 1'b1, ed: 4'd1, es: 2, eo: 1'b0};
    vecs[3] = '{key: 4'd7, ef: 1'b1, ed: 4'd2, es: 2, eo: 1'b0};
    vecs[4] = '{key: 4'd9, ef: 1'b0, ed: 4'd0, es: 2, eo: 1'b0};
    vecs[5] = '{key: 4'd2, ef: 1'b1, ed: 4'd3, es: 1, eo: 1'b0};
    vecs[6] = '{key: 4'd0, ef: 1'b0, ed: 4'd0, es: 2, eo: 1'b0};
    vecs[7] = '{key: 4'd3, ef: 1'b0, ed: 4'd0, es: 2, eo: 1'b0};
    vecs[8] = '{key: 4'd8, ef: 1'b1, ed: 4'd9, es: 1, eo: 1'b0};

    rst_n   = 1'b0;
    i_start = 1'b0;
    i_key   = '0;
    load_fixed_tree();
    repeat (2) @(negedge clk);
    chk("reset_outputs", {o_busy, o_done, o_found, o_data, o_steps, o_overrun,
                          o_node_address, o_node_key}, 0);
    rst_n = 1'b1;

    // Consecutive entries run back-to-back: each start lands one cycle after the prior done.
    for (int i = 0; i < 9; i++) begin
      search(vecs[i].key, 1'b0, 4'd0, cyc);
      check_result($sformatf("vec%0d", i), vecs[i].ef, vecs[i].ed, vecs[i].es, vecs[i].eo, cyc);
    end

    // start pulsed while busy with a different key is dropped
    search(4'd5, 1'b1, 4'd8, cyc);
    check_result("glitch_busy", 1'b1, 4'd6, 1, 1'b0, cyc);
    // start during the DONE cycle is dropped too
    i_start = 1'b1;
    i_key   = 4'd8;
    @(negedge clk);
    i_start = 1'b0;
    chk("done_cycle_start_busy", o_busy, 0);
    chk("done_cycle_start_data", o_data, 6);
    @(negedge clk);
    chk("done_cycle_start_still_idle", o_busy, 0);

    load_loop_tree();
    search(4'd4, 1'b0, 4'd0, cyc);
    check_result("self_loop", 1'b0, 4'd0, TB_MAX, 1'b1, cyc);

    // Reset during the second ISSUE of key 7
    load_fixed_tree();
    @(negedge clk);
    i_start = 1'b1;
    i_key   = 4'd7;
    repeat (3) begin
      @(negedge clk);
      i_start = 1'b0;
    end
    chk("second_issue_addr", o_node_address, 3);
    chk("second_issue_busy", o_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midwalk_reset_async", {o_busy, o_done, o_found, o_data, o_steps, o_overrun,
                                o_node_address, o_node_key}, 0);
    @(posedge clk);
    #1;
    chk("midwalk_reset_edge", {o_busy, o_done, o_found, o_data, o_steps, o_overrun,
                               o_node_address, o_node_key}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (o_done || o_busy) saw_done = 1'b1;
    end
    chk("no_done_after_reset", saw_done, 0);
    search(4'd7, 1'b0, 4'd0, cyc);
    check_result("after_reset", 1'b1, 4'd2, 2, 1'b0, cyc);

    for (int t = 0; t < 6; t++) begin
      load_random_tree();
      for (int j = 0; j < 8; j++) begin
        rk = 4'($urandom_range(0, 15));
        walk(rk, mf, md, ms, mo);
        search(rk, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), cyc);
        check_result($sformatf("rand%0d_%0d_k%0d", t, j, rk), mf, md, ms, mo, cyc);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
